// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one add/shift iteration per clock,
// WIDTH iterations per product, start/done handshake with back-to-back starts.
module seq_shift_add_mult #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mq_q, mq_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       sum_ext;
    logic [2*WIDTH-1:0]   shifted;
    logic                 accept;

    always_comb begin
        sum_ext = {1'b0, acc_q};
        if (mq_q[0]) begin
            sum_ext = {1'b0, acc_q} + {1'b0, mcand_q};
        end
        // {c,sum,mq} >> 1 with the consumed mq[0] dropped; carry lands in acc MSB
        shifted = {sum_ext, mq_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: accept = start;
            RUN: begin
                acc_d = shifted[2*WIDTH-1:WIDTH];
                mq_d  = shifted[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = shifted;
                    state_d   = DONE;
                end
            end
            DONE: begin
                accept  = start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            mcand_d = a;
            mq_d    = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult (WIDTH=4) with hand-computed products.
module tb_seq_shift_add_mult;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Counts rising edges until done is seen (bounded); checks busy/done exclusivity.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy && done) check({tag, "_busy_done_excl"}, 1, 0);
        end while (!done && n < 20);
    endtask

    // Start one op from IDLE, scramble operands during RUN, check latency and product.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [2*W-1:0] exp);
        int n;
        @(negedge clk);
        a = ta;
        b = tb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta;
        b = ~tb;
        check({tag, "_busy"}, 32'(busy), 1);
        wait_done(tag, n);
        check({tag, "_latency"}, n, W);
        check({tag, "_product"}, 32'(product), 32'(exp));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("m13x11", 4'd13, 4'd11, 8'h8F);
        repeat (3) @(posedge clk);
        #1;
        check("m13x11_idle_hold", 32'(product), 32'h8F);
        check("m13x11_idle_busy", 32'(busy), 0);

        run_op("m15x15", 4'd15, 4'd15, 8'hE1);
        run_op("m15x1", 4'd15, 4'd1, 8'h0F);
        run_op("m1x15", 4'd1, 4'd15, 8'h0F);
        run_op("m0x9", 4'd0, 4'd9, 8'h00);
        run_op("m7x0", 4'd7, 4'd0, 8'h00);

        // start held through RUN with operands changed: first result unaffected,
        // then 2*2 begins back-to-back from DONE
        @(negedge clk);
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 4'd2;
        b = 4'd2;
        wait_done("hold", n);
        check("hold_latency", n, W);
        check("hold_product", 32'(product), 15);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_b2b_busy", 32'(busy), 1);
        check("hold_b2b_done", 32'(done), 0);
        check("hold_b2b_prod_keep", 32'(product), 15);
        wait_done("hold2", n);
        check("hold2_latency", n, W);
        check("hold2_product", 32'(product), 4);

        // back-to-back: new start raised during the DONE cycle
        @(negedge clk);
        a = 4'd2;
        b = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_first", n);
        check("b2b_first_product", 32'(product), 6);
        a = 4'd6;
        b = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy_next", 32'(busy), 1);
        wait_done("b2b_second", n);
        check("b2b_done_spacing", n + 1, W + 1);
        check("b2b_product", 32'(product), 42);

        // async reset between edges, two cycles into RUN
        @(negedge clk);
        a = 4'd3;
        b = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_idle_busy", 32'(busy), 0);
        run_op("m9x5", 4'd9, 4'd5, 8'h2D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Sequential unsigned shift-and-add multiplier built around the team's 4-bit ripple add/sub datapath.
- Sits directly downstream of the adder. Each cycle it feeds the adder the running partial sum and the multiplicand, then consumes the sum and carry-out.
- Produces a 2*WIDTH-bit product after WIDTH iterations, using a start/done handshake.
- Replaces the unfinished combinational 2-bit multiplier for wider operands.

Parameters:
- WIDTH, 4, operand width in bits. Product is 2*WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled on the rising edge.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  result; holds its value until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, no clock needed):
  - state=IDLE; busy=0; done=0; product=0.
  - Internal multiplicand, accumulator, multiplier/quotient register and iteration counter all =0.
- Reset mid-operation aborts the multiply with no partial result kept. Normal operation resumes on the first rising edge after rst_n goes high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → capture mcand=a, mq=b, acc=0 (WIDTH bits), cnt=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN, one iteration per edge:
  - If mq[0]=1: {c,sum} = acc + mcand (carry-in 0, unsigned, WIDTH+1 bits). Otherwise {c,sum} = {0,acc}.
  - Then shift right as one 2*WIDTH+1 vector: {c,sum,mq} >> 1 → new {acc,mq}.
  - cnt increments by 1.
  - On the edge where cnt reaches WIDTH-1, i.e. the WIDTH-th iteration: perform the final iteration, load product={acc,mq} from the post-shift values, and go to DONE.
- DONE:
  - done=1 for exactly this one cycle; product is valid.
  - Next edge: if start=1, accept a new operation exactly as in IDLE and go to RUN (back-to-back supported). Otherwise go to IDLE.
- Latency: with start accepted at edge E0, busy=1 from E0 through EW. done=1 and product valid from EW until E(W+1). This gives WIDTH cycles of latency from the capture edge; throughput is one result per WIDTH+1 cycles.
- Handshake rules:
  - start is ignored in RUN; a and b changes during RUN have no effect.
  - busy and done are never high in the same cycle.
- Width rules:
  - The adder carry-out must never be dropped; it becomes the MSB of acc after the shift.
  - No overflow is possible: max result is (2^W-1)^2 < 2^(2W).
- Outputs are registered/state-decoded only, with no combinational path from inputs to outputs.
- product changes only on the edge entering DONE, or on reset.

Test Plan:
- Reset, then start with a=13, b=11 (WIDTH=4) → busy high for 4 cycles; done pulses once; product=143 (0x8F); product holds 0x8F in IDLE afterwards.
- Carry path: a=15, b=15 → product=225 (0xE1). Also a=15, b=1 → 0x0F, and a=1, b=15 → 0x0F.
- Zero operands: a=0, b=9 and a=7, b=0 → product=0x00, with done still arriving on schedule.
- Start while busy: start=1 held throughout RUN with a and b changed to 2,2 → ignored; first result correct. Since start is still high in DONE, a second operation 2*2=4 begins back-to-back.
- Back-to-back: start=1 in DONE with a=6, b=7 → busy re-asserts the next cycle; done pulses W+1 cycles after the previous done; product=42 (0x2A).
- Async reset: drop rst_n two cycles into RUN, between clock edges → busy, done and product go to 0 immediately without a clock edge. After release, a fresh 9*5 gives product=45 (0x2D).
